// File: rtl/lmac_pkg.sv
// lmac_pkg: shared widths and FSM state type for the LMAC register reader
package lmac_pkg;
  localparam int ADDR_W = 16;
  localparam int DATA_W = 32;
  localparam int CNT_W = 16;
  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP, S_GUARD} state_t;
endpackage

// File: rtl/lmac_sat_cnt.sv
// lmac_sat_cnt: saturating up-counter with synchronous clear
module lmac_sat_cnt
  import lmac_pkg::*;
#(
  parameter int W = CNT_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);
  always_ff @(posedge clk)
    if (!rst_n || clr) cnt <= '0;
    else if (inc && cnt != '1) cnt <= cnt + 1'b1;
endmodule

// File: rtl/lmac_reg_reader.sv
// lmac_reg_reader: single-outstanding host read bridge to the MAC register port with timeout, guard window and event counters
module lmac_reg_reader
  import lmac_pkg::*;
#(
  parameter int TIMEOUT_CYC = 255,
  parameter int GUARD_CYC   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              req_ready,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_data,
  output logic              resp_err,
  input  logic              resp_ready,
  output logic [ADDR_W-1:0] host_addr_reg,
  output logic              reg_rd_start,
  input  logic              reg_rd_done_out,
  input  logic [DATA_W-1:0] FMAC_REGDOUT,
  output logic [CNT_W-1:0]  timeout_cnt,
  output logic [CNT_W-1:0]  stray_cnt
);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] GRD_LAST = CNT_W'(GUARD_CYC - 1);
  state_t state;
  logic [CNT_W-1:0] timer;
  logic tmo_inc, stray_inc;
  assign req_ready = state == S_IDLE;
  assign tmo_inc   = state == S_WAIT && !reg_rd_done_out && timer == TMO_LAST;
  assign stray_inc = reg_rd_done_out && state != S_WAIT;
  always_ff @(posedge clk)
    if (!rst_n) begin
      state         <= S_IDLE;
      timer         <= '0;
      reg_rd_start  <= 1'b0;
      host_addr_reg <= '0;
      resp_valid    <= 1'b0;
      resp_data     <= '0;
      resp_err      <= 1'b0;
    end else
      case (state)
        S_IDLE:
          if (req_valid) begin
            host_addr_reg <= req_addr;
            reg_rd_start  <= 1'b1;
            state         <= S_ISSUE;
          end
        S_ISSUE: begin
          reg_rd_start <= 1'b0;
          timer        <= '0;
          state        <= S_WAIT;
        end
        S_WAIT:
          if (reg_rd_done_out) begin
            resp_data  <= FMAC_REGDOUT;
            resp_err   <= 1'b0;
            resp_valid <= 1'b1;
            state      <= S_RESP;
          end else if (timer == TMO_LAST) begin
            resp_data <= '0;
            resp_err  <= 1'b1;
            timer     <= '0;
            state     <= S_GUARD;
          end else timer <= timer + 1'b1;
        S_GUARD:
          if (timer == GRD_LAST) begin
            resp_valid <= 1'b1;
            state      <= S_RESP;
          end else timer <= timer + 1'b1;
        S_RESP:
          if (resp_ready) begin
            resp_valid <= 1'b0;
            state      <= S_IDLE;
          end
        default: state <= S_IDLE;
      endcase
  lmac_sat_cnt u_tmo_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (1'b0),
    .inc  (tmo_inc),
    .cnt  (timeout_cnt)
  );
  lmac_sat_cnt u_stray_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (1'b0),
    .inc  (stray_inc),
    .cnt  (stray_cnt)
  );
endmodule

// File: tb/tb_lmac_reg_reader.sv
// tb_lmac_reg_reader: scoreboard bench for the LMAC register reader
module tb_lmac_reg_reader;
  import lmac_pkg::*;
  localparam int T = 12;
  localparam int G = 6;
  logic clk = 0, rst_n = 0, req_valid = 0, resp_ready = 1, reg_rd_done_out = 0;
  logic sc_inc = 0, sc_clr = 0;
  logic [15:0] req_addr = 0;
  logic [31:0] FMAC_REGDOUT = 0;
  logic req_ready, resp_valid, resp_err, reg_rd_start;
  logic [31:0] resp_data;
  logic [15:0] host_addr_reg, timeout_cnt, stray_cnt;
  logic [3:0] sc_cnt;
  int total = 0, bad = 0, starts = 0;
  typedef struct {
    logic [31:0] data;
    logic        err;
  } exp_t;
  exp_t q[$];
  lmac_reg_reader #(.TIMEOUT_CYC(T), .GUARD_CYC(G)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid      (req_valid),
    .req_addr       (req_addr),
    .req_ready      (req_ready),
    .resp_valid     (resp_valid),
    .resp_data      (resp_data),
    .resp_err       (resp_err),
    .resp_ready     (resp_ready),
    .host_addr_reg  (host_addr_reg),
    .reg_rd_start   (reg_rd_start),
    .reg_rd_done_out(reg_rd_done_out),
    .FMAC_REGDOUT   (FMAC_REGDOUT),
    .timeout_cnt    (timeout_cnt),
    .stray_cnt      (stray_cnt)
  );
  lmac_sat_cnt #(.W(4)) u_sc (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (sc_clr),
    .inc  (sc_inc),
    .cnt  (sc_cnt)
  );
  always #5 clk = ~clk;
  always @(negedge clk) if (reg_rd_start) starts++;
  always @(negedge clk)
    if (rst_n && resp_valid && resp_ready) begin
      exp_t e;
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL resp_unexpected: got data=%h err=%b want no response", resp_data, resp_err);
      end else begin
        e = q.pop_front();
        if (resp_data !== e.data || resp_err !== e.err) begin
          bad++;
          $display("FAIL resp_payload: got data=%h err=%b want data=%h err=%b", resp_data, resp_err, e.data, e.err);
        end
      end
    end
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end
  task tick;
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask
  task automatic do_read(input logic [15:0] addr, input int done_k, input logic [31:0] data,
                         input logic err, input int lat, input int hold);
    int k = 0;
    int s0 = starts;
    logic ok = 1;
    q.push_back('{err ? 32'h0 : data, err});
    resp_ready = (hold == 0);
    req_valid = 1;
    req_addr = addr;
    do begin
      reg_rd_done_out = (k == done_k);
      FMAC_REGDOUT = (k == done_k) ? data : 32'hFFFF_0000;
      tick;
      k++;
      if (k == 1) begin
        req_valid = 0;
        check("start_pulse", {31'b0, reg_rd_start}, 1);
        check("addr_latched", {16'b0, host_addr_reg}, {16'b0, addr});
        check("busy_ready", {31'b0, req_ready}, 0);
      end
    end while (!resp_valid && k < 400);
    reg_rd_done_out = 0;
    check("latency", k, lat);
    check("one_start", starts - s0, 1);
    if (hold > 0) begin
      req_valid = 1;
      req_addr = 16'hFFFF;
      repeat (hold) begin
        tick;
        ok &= resp_valid && resp_data == (err ? 32'h0 : data) && !req_ready && !reg_rd_start;
      end
      req_valid = 0;
      check("hold_stable", {31'b0, ok}, 1);
      check("hold_no_start", starts - s0, 1);
      resp_ready = 1;
    end
    check("resp_busy_ready", {31'b0, req_ready}, 0);
    tick;
    check("resp_done", {31'b0, resp_valid}, 0);
    check("back_idle", {31'b0, req_ready}, 1);
  endtask
  initial begin
    logic quiet;
    repeat (3) tick;
    check("rst_resp_valid", {31'b0, resp_valid}, 0);
    check("rst_resp_data", resp_data, 0);
    check("rst_resp_err", {31'b0, resp_err}, 0);
    check("rst_host_addr", {16'b0, host_addr_reg}, 0);
    check("rst_start", {31'b0, reg_rd_start}, 0);
    check("rst_tmo_cnt", {16'b0, timeout_cnt}, 0);
    check("rst_stray_cnt", {16'b0, stray_cnt}, 0);
    rst_n = 1;
    tick;
    check("rst_req_ready", {31'b0, req_ready}, 1);
    do_read(16'h0010, 3, 32'hDEADBEEF, 0, 4, 0);
    do_read(16'hA5A5, 2, 32'h12345678, 0, 3, 0);
    do_read(16'h0100, -1, 32'h0, 1, T + G + 2, 0);
    check("tmo_cnt_1", {16'b0, timeout_cnt}, 1);
    check("stray_cnt_0", {16'b0, stray_cnt}, 0);
    do_read(16'h0200, T + 6, 32'h5555AAAA, 1, T + G + 2, 0);
    check("tmo_cnt_2", {16'b0, timeout_cnt}, 2);
    check("guard_stray", {16'b0, stray_cnt}, 1);
    do_read(16'h0204, 4, 32'hCAFEF00D, 0, 5, 0);
    do_read(16'h0300, 2, 32'h0BADF00D, 0, 3, 10);
    do_read(16'h0304, T + 1, 32'h600DD0E5, 0, T + 2, 0);
    check("done_beats_tmo", {16'b0, timeout_cnt}, 2);
    reg_rd_done_out = 1;
    tick;
    reg_rd_done_out = 0;
    check("idle_stray", {16'b0, stray_cnt}, 2);
    check("idle_no_resp", {31'b0, resp_valid}, 0);
    check("idle_ready", {31'b0, req_ready}, 1);
    req_valid = 1;
    req_addr = 16'h003C;
    tick;
    req_valid = 0;
    repeat (2) tick;
    rst_n = 0;
    tick;
    check("mid_rst_host_addr", {16'b0, host_addr_reg}, 0);
    check("mid_rst_resp_data", resp_data, 0);
    check("mid_rst_resp_valid", {31'b0, resp_valid}, 0);
    check("mid_rst_start", {31'b0, reg_rd_start}, 0);
    check("mid_rst_tmo_cnt", {16'b0, timeout_cnt}, 0);
    check("mid_rst_stray_cnt", {16'b0, stray_cnt}, 0);
    rst_n = 1;
    tick;
    check("mid_rst_ready", {31'b0, req_ready}, 1);
    reg_rd_done_out = 1;
    FMAC_REGDOUT = 32'h11112222;
    tick;
    reg_rd_done_out = 0;
    quiet = 1;
    repeat (5) begin
      tick;
      quiet &= !resp_valid;
    end
    check("late_done_stray", {16'b0, stray_cnt}, 1);
    check("late_done_no_resp", {31'b0, quiet}, 1);
    sc_clr = 1;
    tick;
    sc_clr = 0;
    sc_inc = 1;
    repeat (3) tick;
    check("sat_counts", {28'b0, sc_cnt}, 3);
    repeat (17) tick;
    check("sat_holds_max", {28'b0, sc_cnt}, 15);
    sc_inc = 0;
    sc_clr = 1;
    tick;
    sc_clr = 0;
    check("sat_clear", {28'b0, sc_cnt}, 0);
    repeat (2) tick;
    check("queue_empty", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
